ahb_slave_interface: RTL and testbench
======================================

AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 SHALL use a single clock and a synchronous, active-high reset; all state updates on the rising edge of Hclk.
REQ-002 SHALL have ports:
  Hclk  in  1  bus clock
  Hreset  in  1  synchronous active-high reset
  Hwrite  in  1  1=write, 0=read
  Hreadyin  in  1  transfer-accept qualifier from bus
  Htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
  Hburst  in  3  AHB burst type
  Hsize  in  3  transfer size
  Haddr  in  32  address
  Hwdata  in  32  write data
  Prdata  in  32  read data returned from APB side
  valid  out  1  qualified in-range transfer this cycle
  Haddr1, Haddr2  out  32  address pipeline stages 1, 2
  Hwdata1, Hwdata2  out  32  write-data pipeline stages 1, 2
  Hwritereg  out  1  registered Hwrite
  tempselx  out  3  one-hot peripheral select
  Hrdata  out  32  read data to master
  Hresp  out  2  00 OKAY, 01 ERROR
  err_stall  out  1  high in first ERROR cycle (bridge drives Hreadyout low)
  beat_cnt  out  5  beats accepted in current burst
  burst_last  out  1  current valid beat completes a fixed-length burst

Function
REQ-003 valid SHALL be combinational: Hreadyin=1 AND Htrans in {2,3} AND 0x8000_0000 <= Haddr <= 0x8BFF_FFFF.
REQ-004 tempselx SHALL decode Haddr combinationally: 0x8000_0000-0x83FF_FFFF -> 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; otherwise 000.
REQ-005 Each edge SHALL perform Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite, unconditionally.
REQ-006 Hrdata SHALL equal Prdata combinationally (zero latency).
REQ-007 Expected beat count SHALL be latched from Hburst on each valid NONSEQ: 0->1, 1->0 (unbounded INCR), 2/3->4, 4/5->8, 6/7->16.
REQ-008 FSM states SHALL be IDLE, BURST, ERR1, ERR2.
REQ-009 IDLE: valid NONSEQ -> BURST with beat_cnt<=1; valid SEQ -> ERR1; otherwise stay.
REQ-010 BURST: valid SEQ with beat_cnt < expected, or expected=0 -> beat_cnt+1 (saturate at 31); valid SEQ with beat_cnt=expected, expected!=0 -> ERR1; valid NONSEQ -> restart burst with beat_cnt<=1; Htrans=BUSY -> hold; Htrans=IDLE -> IDLE, beat_cnt<=0, no error.
REQ-011 valid with Hsize>2, in IDLE or BURST, SHALL go to ERR1 with priority over REQ-009/REQ-010.
REQ-012 ERR1 SHALL drive Hresp=01 and err_stall=1, then go to ERR2; ERR2 SHALL drive Hresp=01 and err_stall=0, then go to IDLE with beat_cnt<=0; inputs ignored in ERR1/ERR2.
REQ-013 Hresp SHALL be 00 in IDLE and BURST.
REQ-014 burst_last SHALL be combinational: valid AND expected!=0 AND next beat_cnt equals expected (SINGLE NONSEQ asserts it).
REQ-015 Hreadyin=0 SHALL freeze FSM state and beat_cnt; the pipeline still advances per REQ-005.

Reset
REQ-016 Hreset=1 at an edge SHALL clear all pipeline registers, Hwritereg, and beat_cnt, clear the expected count, and enter IDLE (Hresp=00, err_stall=0); reset overrides every simultaneous event, including mid-burst and in ERR1/ERR2.

Structure
REQ-017 Shared package ahb_bridge_pkg SHALL hold: the Htrans/Hburst encodings, the address-map bounds, the Hresp codes, and the FSM state enum.
REQ-018 Address decode (valid range + tempselx) SHALL be a sub-module ahb_addr_decode; everything else stays in ahb_slave_interface.

Verification
REQ-019 Single write, Haddr=0x8000_0001, Htrans=2, Hwdata=0x80 next cycle -> valid=1, tempselx=001, burst_last=1; Haddr2=0x8000_0001 and Hwdata1=0x80 two edges later.
REQ-020 INCR4 write from 0x8400_0000 (NONSEQ + 3 SEQ) -> tempselx=010, beat_cnt 1,2,3,4, burst_last only on the 4th beat, Hresp=00 throughout.
REQ-021 Fifth SEQ after INCR4 -> ERROR: Hresp=01 for 2 cycles, err_stall=1 in the first only, then IDLE with beat_cnt=0.
REQ-022 Haddr=0x9000_0000 NONSEQ -> valid=0, tempselx=000, FSM stays IDLE; Hsize=3 NONSEQ at 0x8800_0000 -> ERROR sequence.
REQ-023 Hreset asserted during beat 2 of INCR8 -> next cycle IDLE, beat_cnt=0, Haddr1=Haddr2=0, Hresp=00.
REQ-024 INCR with Hreadyin=0 for 3 cycles mid-burst, then BUSY -> beat_cnt holds; Hrdata tracks Prdata=0xDEAD_BEEF same cycle.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared encodings, address map and FSM state type for the AHB side of the AHB-to-APB bridge.
package ahb_bridge_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BEAT_W = 5;
   localparam int unsigned SEL_W  = 3;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic [2:0] HSIZE_MAX = 3'd2;

   localparam logic [ADDR_W-1:0] ADDR_LO = 32'h8000_0000;
   localparam logic [ADDR_W-1:0] SLV0_HI = 32'h83FF_FFFF;
   localparam logic [ADDR_W-1:0] SLV1_HI = 32'h87FF_FFFF;
   localparam logic [ADDR_W-1:0] ADDR_HI = 32'h8BFF_FFFF;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_ERR1  = 2'd2,
      ST_ERR2  = 2'd3
   } ahb_state_e;

   // Beats expected for a burst type; 0 means unbounded INCR.
   function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
      logic [BEAT_W-1:0] beats;
      case (hburst)
         HBURST_SINGLE:               beats = BEAT_W'(1);
         HBURST_INCR:                 beats = BEAT_W'(0);
         HBURST_WRAP4, HBURST_INCR4:  beats = BEAT_W'(4);
         HBURST_WRAP8, HBURST_INCR8:  beats = BEAT_W'(8);
         default:                     beats = BEAT_W'(16);
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Address-map decode: qualifies active in-range transfers and produces the one-hot peripheral select.
module ahb_addr_decode
   import ahb_bridge_pkg::*;
(
   input  logic [ADDR_W-1:0] i_haddr,
   input  logic [1:0]        i_htrans,
   input  logic              i_hreadyin,
   output logic              o_valid,
   output logic [SEL_W-1:0]  o_tempselx
);

   logic w_in_range;
   logic w_active;

   assign w_in_range = (i_haddr >= ADDR_LO) && (i_haddr <= ADDR_HI);
   assign w_active   = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
   assign o_valid    = i_hreadyin && w_active && w_in_range;

   always_comb begin
      o_tempselx = '0;
      if ((i_haddr >= ADDR_LO) && (i_haddr <= SLV0_HI)) begin
         o_tempselx = 3'b001;
      end else if ((i_haddr > SLV0_HI) && (i_haddr <= SLV1_HI)) begin
         o_tempselx = 3'b010;
      end else if ((i_haddr > SLV1_HI) && (i_haddr <= ADDR_HI)) begin
         o_tempselx = 3'b100;
      end
   end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the bridge: address/data pipeline, burst beat tracking and
// two-cycle ERROR response generation.
module ahb_slave_interface
   import ahb_bridge_pkg::*;
(
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              Hwrite,
   input  logic              Hreadyin,
   input  logic [1:0]        Htrans,
   input  logic [2:0]        Hburst,
   input  logic [2:0]        Hsize,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [DATA_W-1:0] Prdata,
   output logic              valid,
   output logic [ADDR_W-1:0] Haddr1,
   output logic [ADDR_W-1:0] Haddr2,
   output logic [DATA_W-1:0] Hwdata1,
   output logic [DATA_W-1:0] Hwdata2,
   output logic              Hwritereg,
   output logic [SEL_W-1:0]  tempselx,
   output logic [DATA_W-1:0] Hrdata,
   output logic [1:0]        Hresp,
   output logic              err_stall,
   output logic [BEAT_W-1:0] beat_cnt,
   output logic              burst_last
);

   ahb_state_e        r_state;
   ahb_state_e        w_state_next;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic [BEAT_W-1:0] w_beat_next;
   logic [BEAT_W-1:0] r_expected;
   logic [BEAT_W-1:0] w_expected_next;
   logic [ADDR_W-1:0] r_haddr1;
   logic [ADDR_W-1:0] r_haddr2;
   logic [DATA_W-1:0] r_hwdata1;
   logic [DATA_W-1:0] r_hwdata2;
   logic              r_hwritereg;
   logic              w_valid;
   logic [SEL_W-1:0]  w_tempselx;
   logic              w_nonseq;
   logic              w_seq;
   logic              w_bad_size;
   logic              w_active_state;

   ahb_addr_decode u_addr_decode (
      .i_haddr    (Haddr),
      .i_htrans   (Htrans),
      .i_hreadyin (Hreadyin),
      .o_valid    (w_valid),
      .o_tempselx (w_tempselx)
   );

   assign w_nonseq       = (Htrans == HTRANS_NONSEQ);
   assign w_seq          = (Htrans == HTRANS_SEQ);
   assign w_bad_size     = (Hsize > HSIZE_MAX);
   assign w_active_state = (r_state == ST_IDLE) || (r_state == ST_BURST);

   // State, beat counter and address/data pipeline
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         r_state     <= ST_IDLE;
         r_beat_cnt  <= '0;
         r_expected  <= '0;
         r_haddr1    <= '0;
         r_haddr2    <= '0;
         r_hwdata1   <= '0;
         r_hwdata2   <= '0;
         r_hwritereg <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_beat_cnt  <= w_beat_next;
         r_expected  <= w_expected_next;
         r_haddr1    <= Haddr;
         r_haddr2    <= r_haddr1;
         r_hwdata1   <= Hwdata;
         r_hwdata2   <= r_hwdata1;
         r_hwritereg <= Hwrite;
      end
   end

   // Next state; Hreadyin low freezes tracking, ERR states ignore the bus
   always_comb begin
      w_state_next    = r_state;
      w_beat_next     = r_beat_cnt;
      w_expected_next = r_expected;
      unique case (r_state)
         ST_IDLE, ST_BURST: begin
            if (Hreadyin) begin
               if (w_valid && w_bad_size) begin
                  w_state_next = ST_ERR1;
               end else if (w_valid && w_nonseq) begin
                  w_state_next    = ST_BURST;
                  w_beat_next     = BEAT_W'(1);
                  w_expected_next = burst_beats(Hburst);
               end else if (r_state == ST_IDLE) begin
                  if (w_valid && w_seq) begin
                     w_state_next = ST_ERR1;
                  end
               end else if (w_valid && w_seq) begin
                  if ((r_expected == '0) || (r_beat_cnt < r_expected)) begin
                     if (r_beat_cnt != '1) begin
                        w_beat_next = r_beat_cnt + BEAT_W'(1);
                     end
                  end else begin
                     w_state_next = ST_ERR1;
                  end
               end else if (Htrans == HTRANS_IDLE) begin
                  w_state_next = ST_IDLE;
                  w_beat_next  = '0;
               end
            end
         end
         ST_ERR1: begin
            w_state_next = ST_ERR2;
         end
         ST_ERR2: begin
            w_state_next = ST_IDLE;
            w_beat_next  = '0;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_beat_next  = '0;
         end
      endcase
   end

   assign valid      = w_valid;
   assign tempselx   = w_tempselx;
   assign Hrdata     = Prdata;
   assign Haddr1     = r_haddr1;
   assign Haddr2     = r_haddr2;
   assign Hwdata1    = r_hwdata1;
   assign Hwdata2    = r_hwdata2;
   assign Hwritereg  = r_hwritereg;
   assign beat_cnt   = r_beat_cnt;
   assign Hresp      = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign err_stall  = (r_state == ST_ERR1);

   // Beat that completes a fixed-length burst without triggering an error
   assign burst_last = w_valid && w_active_state && (w_state_next != ST_ERR1)
                       && (w_expected_next != '0) && (w_beat_next == w_expected_next);

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed bench for ahb_slave_interface: single write, INCR4 + overrun error, decode
// boundaries, size error, reset mid-burst and INCR with wait states.
module tb_ahb_slave_interface;

   logic        Hclk;
   logic        Hreset;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [2:0]  Hburst;
   logic [2:0]  Hsize;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic        valid;
   logic [31:0] Haddr1;
   logic [31:0] Haddr2;
   logic [31:0] Hwdata1;
   logic [31:0] Hwdata2;
   logic        Hwritereg;
   logic [2:0]  tempselx;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        err_stall;
   logic [4:0]  beat_cnt;
   logic        burst_last;

   int checks   = 0;
   int failures = 0;

   ahb_slave_interface dut (
      .Hclk       (Hclk),
      .Hreset     (Hreset),
      .Hwrite     (Hwrite),
      .Hreadyin   (Hreadyin),
      .Htrans     (Htrans),
      .Hburst     (Hburst),
      .Hsize      (Hsize),
      .Haddr      (Haddr),
      .Hwdata     (Hwdata),
      .Prdata     (Prdata),
      .valid      (valid),
      .Haddr1     (Haddr1),
      .Haddr2     (Haddr2),
      .Hwdata1    (Hwdata1),
      .Hwdata2    (Hwdata2),
      .Hwritereg  (Hwritereg),
      .tempselx   (tempselx),
      .Hrdata     (Hrdata),
      .Hresp      (Hresp),
      .err_stall  (err_stall),
      .beat_cnt   (beat_cnt),
      .burst_last (burst_last)
   );

   initial begin
      Hclk = 1'b0;
      forever #5 Hclk = ~Hclk;
   end

   task automatic cyc();
      @(negedge Hclk);
   endtask

   task automatic bus(input logic [1:0] trans, input logic [31:0] addr, input logic [31:0] wdata);
      Htrans = trans;
      Haddr  = addr;
      Hwdata = wdata;
   endtask

   task automatic test_reset();
      Hreset = 1'b1; Hwrite = 1'b1; Hreadyin = 1'b1; Htrans = 2'd2; Hburst = 3'd3; Hsize = 3'd2;
      Haddr = 32'h8000_0010; Hwdata = 32'hFFFF_FFFF; Prdata = 32'hA5A5_0F0F;
      cyc(); cyc();
      checks++;
      if ({Haddr1, Haddr2, Hwdata1, Hwdata2} !== 128'd0) begin
         failures++; $display("FAIL reset_pipe: got %h %h %h %h expected all 0", Haddr1, Haddr2, Hwdata1, Hwdata2);
      end
      checks++;
      if ({Hwritereg, beat_cnt, Hresp, err_stall} !== 9'd0) begin
         failures++; $display("FAIL reset_state: got wreg=%0b beat=%0d resp=%0d stall=%0b expected 0 0 0 0",
                              Hwritereg, beat_cnt, Hresp, err_stall);
      end
      checks++;
      if (Hrdata !== 32'hA5A5_0F0F) begin
         failures++; $display("FAIL reset_hrdata: got %h expected a5a50f0f", Hrdata);
      end
      Hreset = 1'b0; Hwrite = 1'b0; Hburst = 3'd0;
      bus(2'd0, 32'h0, 32'h0);
      cyc();
   endtask

   task automatic test_single_write();
      Hwrite = 1'b1; Hburst = 3'd0; Hsize = 3'd2;
      bus(2'd2, 32'h8000_0001, 32'h0);
      #1;
      checks++;
      if ({valid, tempselx, burst_last} !== {1'b1, 3'b001, 1'b1}) begin
         failures++; $display("FAIL single_decode: got valid=%0b sel=%b last=%0b expected 1 001 1", valid, tempselx, burst_last);
      end
      cyc();
      checks++;
      if ({beat_cnt, Haddr1} !== {5'd1, 32'h8000_0001}) begin
         failures++; $display("FAIL single_beat: got beat=%0d haddr1=%h expected 1 80000001", beat_cnt, Haddr1);
      end
      bus(2'd0, 32'h0, 32'h0000_0080);
      cyc();
      checks++;
      if ({Haddr2, Hwdata1, Hwritereg, beat_cnt} !== {32'h8000_0001, 32'h0000_0080, 1'b1, 5'd0}) begin
         failures++; $display("FAIL single_pipe: got haddr2=%h hwdata1=%h wreg=%0b beat=%0d expected 80000001 00000080 1 0",
                              Haddr2, Hwdata1, Hwritereg, beat_cnt);
      end
   endtask

   task automatic test_incr4_overrun();
      Hwrite = 1'b1; Hburst = 3'd3; Hsize = 3'd2;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (beat_cnt !== 5'(i)) begin
            failures++; $display("FAIL incr4_beat%0d: got %0d expected %0d", i, beat_cnt, i);
         end
         bus((i == 0) ? 2'd2 : 2'd3, 32'h8400_0000 + 32'(4 * i), 32'(i));
         #1;
         checks++;
         if ({tempselx, burst_last, Hresp} !== {3'b010, (i == 3), 2'b00}) begin
            failures++; $display("FAIL incr4_cycle%0d: got sel=%b last=%0b resp=%0d expected 010 %0b 0",
                                 i, tempselx, burst_last, Hresp, (i == 3));
         end
         cyc();
      end
      // NONSEQ offered during the error response must be ignored
      bus(2'd2, 32'h8000_0000, 32'h0);
      checks++;
      if ({Hresp, err_stall} !== {2'b01, 1'b1}) begin
         failures++; $display("FAIL overrun_err1: got resp=%0d stall=%0b expected 1 1", Hresp, err_stall);
      end
      cyc();
      checks++;
      if ({Hresp, err_stall} !== {2'b01, 1'b0}) begin
         failures++; $display("FAIL overrun_err2: got resp=%0d stall=%0b expected 1 0", Hresp, err_stall);
      end
      bus(2'd0, 32'h0, 32'h0);
      cyc();
      checks++;
      if ({Hresp, err_stall, beat_cnt} !== {2'b00, 1'b0, 5'd0}) begin
         failures++; $display("FAIL overrun_idle: got resp=%0d stall=%0b beat=%0d expected 0 0 0", Hresp, err_stall, beat_cnt);
      end
      cyc();
   endtask

   task automatic test_decode_and_size();
      Hwrite = 1'b0; Hburst = 3'd0; Hsize = 3'd2;
      bus(2'd2, 32'h9000_0000, 32'h0);
      #1;
      checks++;
      if ({valid, tempselx} !== {1'b0, 3'b000}) begin
         failures++; $display("FAIL dec_out_range: got valid=%0b sel=%b expected 0 000", valid, tempselx);
      end
      Haddr = 32'h8BFF_FFFF;
      #1;
      checks++;
      if ({valid, tempselx} !== {1'b1, 3'b100}) begin
         failures++; $display("FAIL dec_top_edge: got valid=%0b sel=%b expected 1 100", valid, tempselx);
      end
      Haddr = 32'h8C00_0000;
      #1;
      checks++;
      if ({valid, tempselx} !== {1'b0, 3'b000}) begin
         failures++; $display("FAIL dec_above_top: got valid=%0b sel=%b expected 0 000", valid, tempselx);
      end
      cyc();
      checks++;
      if ({beat_cnt, Hresp} !== {5'd0, 2'b00}) begin
         failures++; $display("FAIL dec_stay_idle: got beat=%0d resp=%0d expected 0 0", beat_cnt, Hresp);
      end
      Haddr = 32'h7FFF_FFFF;
      #1;
      checks++;
      if ({valid, tempselx} !== {1'b0, 3'b000}) begin
         failures++; $display("FAIL dec_below_base: got valid=%0b sel=%b expected 0 000", valid, tempselx);
      end
      bus(2'd1, 32'h8400_0000, 32'h0);
      #1;
      checks++;
      if ({valid, tempselx} !== {1'b0, 3'b010}) begin
         failures++; $display("FAIL dec_busy: got valid=%0b sel=%b expected 0 010", valid, tempselx);
      end
      cyc();
      Hsize = 3'd3;
      bus(2'd2, 32'h8800_0000, 32'h0);
      #1;
      checks++;
      if ({valid, tempselx, burst_last, beat_cnt} !== {1'b1, 3'b100, 1'b0, 5'd0}) begin
         failures++; $display("FAIL size_req: got valid=%0b sel=%b last=%0b beat=%0d expected 1 100 0 0",
                              valid, tempselx, burst_last, beat_cnt);
      end
      cyc();
      Hsize = 3'd2;
      bus(2'd0, 32'h0, 32'h0);
      checks++;
      if ({Hresp, err_stall} !== {2'b01, 1'b1}) begin
         failures++; $display("FAIL size_err1: got resp=%0d stall=%0b expected 1 1", Hresp, err_stall);
      end
      cyc();
      checks++;
      if ({Hresp, err_stall} !== {2'b01, 1'b0}) begin
         failures++; $display("FAIL size_err2: got resp=%0d stall=%0b expected 1 0", Hresp, err_stall);
      end
      cyc();
      checks++;
      if ({Hresp, err_stall, beat_cnt} !== {2'b00, 1'b0, 5'd0}) begin
         failures++; $display("FAIL size_idle: got resp=%0d stall=%0b beat=%0d expected 0 0 0", Hresp, err_stall, beat_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      Hwrite = 1'b1; Hburst = 3'd5; Hsize = 3'd2;
      bus(2'd2, 32'h8000_1000, 32'h1111_1111);
      cyc();
      checks++;
      if (beat_cnt !== 5'd1) begin
         failures++; $display("FAIL rst_mid_beat1: got %0d expected 1", beat_cnt);
      end
      bus(2'd3, 32'h8000_1004, 32'h2222_2222);
      Hreset = 1'b1;
      cyc();
      Hreset = 1'b0;
      bus(2'd0, 32'h0, 32'h0);
      checks++;
      if ({beat_cnt, Haddr1, Haddr2, Hresp, err_stall} !== {5'd0, 32'h0, 32'h0, 2'b00, 1'b0}) begin
         failures++; $display("FAIL rst_mid_clear: got beat=%0d a1=%h a2=%h resp=%0d stall=%0b expected 0 0 0 0 0",
                              beat_cnt, Haddr1, Haddr2, Hresp, err_stall);
      end
      cyc();
   endtask

   task automatic test_incr_wait_states();
      Hwrite = 1'b0; Hburst = 3'd1; Hsize = 3'd2; Hreadyin = 1'b1;
      bus(2'd2, 32'h8400_0100, 32'h0);
      #1;
      checks++;
      if ({valid, burst_last} !== {1'b1, 1'b0}) begin
         failures++; $display("FAIL incr_start: got valid=%0b last=%0b expected 1 0", valid, burst_last);
      end
      cyc();
      bus(2'd3, 32'h8400_0104, 32'h0);
      cyc();
      checks++;
      if (beat_cnt !== 5'd2) begin
         failures++; $display("FAIL incr_beat2: got %0d expected 2", beat_cnt);
      end
      Prdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         Hreadyin = 1'b0;
         bus(2'd3, 32'h8400_0200 + 32'(4 * i), 32'h0);
         #1;
         checks++;
         if ({valid, beat_cnt, Hrdata} !== {1'b0, 5'd2, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL incr_stall%0d: got valid=%0b beat=%0d hrdata=%h expected 0 2 deadbeef",
                                 i, valid, beat_cnt, Hrdata);
         end
         cyc();
         checks++;
         if (Haddr1 !== 32'h8400_0200 + 32'(4 * i)) begin
            failures++; $display("FAIL incr_stall_pipe%0d: got %h expected %h", i, Haddr1, 32'h8400_0200 + 32'(4 * i));
         end
      end
      Hreadyin = 1'b1;
      Prdata = 32'h1234_5678;
      bus(2'd1, 32'h8400_0108, 32'h0);
      #1;
      checks++;
      if ({beat_cnt, Hrdata} !== {5'd2, 32'h1234_5678}) begin
         failures++; $display("FAIL incr_busy: got beat=%0d hrdata=%h expected 2 12345678", beat_cnt, Hrdata);
      end
      cyc();
      bus(2'd3, 32'h8400_0108, 32'h0);
      checks++;
      if (beat_cnt !== 5'd2) begin
         failures++; $display("FAIL incr_busy_hold: got %0d expected 2", beat_cnt);
      end
      cyc();
      bus(2'd0, 32'h0, 32'h0);
      checks++;
      if (beat_cnt !== 5'd3) begin
         failures++; $display("FAIL incr_beat3: got %0d expected 3", beat_cnt);
      end
      cyc();
      checks++;
      if ({beat_cnt, Hresp} !== {5'd0, 2'b00}) begin
         failures++; $display("FAIL incr_end_idle: got beat=%0d resp=%0d expected 0 0", beat_cnt, Hresp);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_incr4_overrun();
      test_decode_and_size();
      test_reset_mid_burst();
      test_incr_wait_states();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
